// File: rtl/dmem_ws_pkg.sv
// Shared types and constants for the wait-state data memory (dmem_ws).
package dmem_ws_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_ws_lane.sv
// Byte-lane steering for dmem_ws: byte enables, merged store word, extended load value
// and a misalign/illegal-mode flag. Purely combinational.
module dmem_ws_lane
  import dmem_ws_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  mode,
  input  logic [1:0]  a_lo,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic [31:0] ld_val,
  output logic        flag
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic [31:0] wd_rep;

  always_comb begin
    case (a_lo)
      2'd0:    b_sel = word[7:0];
      2'd1:    b_sel = word[15:8];
      2'd2:    b_sel = word[23:16];
      default: b_sel = word[31:24];
    endcase
    h_sel = a_lo[1] ? word[31:16] : word[15:0];
  end

  // Illegal modes leave be=0 and ld_val=0, so they neither write nor return data.
  always_comb begin
    be     = 4'b0000;
    ld_val = 32'd0;
    flag   = 1'b0;
    wd_rep = wd;
    case (mode)
      MODE_B, MODE_BU: begin
        be     = 4'b0001 << a_lo;
        wd_rep = {4{wd[7:0]}};
        ld_val = (mode == MODE_B) ? {{24{b_sel[7]}}, b_sel} : {24'd0, b_sel};
      end
      MODE_H, MODE_HU: begin
        be     = a_lo[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wd[15:0]}};
        ld_val = (mode == MODE_H) ? {{16{h_sel[15]}}, h_sel} : {16'd0, h_sel};
        flag   = a_lo[0];
      end
      MODE_W: begin
        be     = 4'b1111;
        ld_val = word;
        flag   = |a_lo;
      end
      default: flag = 1'b1;
    endcase
  end

  always_comb begin
    wr_word = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_ws.sv
// Wait-state data memory with req/ready handshake and RISC-V B/H/W load/store modes.
// Define DMEM_WS_MISALIGN_FAULT_EN to report misaligned or illegal accesses on err.
module dmem_ws
  import dmem_ws_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for req; request fields latched on acceptance
  // WAIT  | wait states, cnt counts down to 0
  // RESP  | one-cycle ready/busy pulse; array access already done

  localparam int         LAT      = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [3:0] CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, go;

  logic        we_q;
  logic [2:0]  mode_q;
  logic [AW+1:0] a_q;
  logic [31:0] wd_q;

  logic        acc_we;
  logic [2:0]  acc_mode;
  logic [AW+1:0] acc_a;
  logic [31:0] acc_wd;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH];
  logic [31:0] cur_word, wr_word, ld_val;
  logic [3:0]  be;
  logic        lane_flag, fault;
  logic [31:0] rd_q;
  logic        err_q;
  logic        unused_a;

  assign unused_a = ^a[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    go      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LAT == 0) begin
            state_d = RESP;
            go      = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go      = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, before the latch.
  always_comb begin
    acc_we   = we_q;
    acc_mode = mode_q;
    acc_a    = a_q;
    acc_wd   = wd_q;
    if (state_q == IDLE) begin
      acc_we   = we;
      acc_mode = mode;
      acc_a    = a[AW+1:0];
      acc_wd   = wd;
    end
  end

  assign acc_idx  = acc_a[AW+1:2];
  assign cur_word = mem[acc_idx];

  dmem_ws_lane u_lane (
    .word    (cur_word),
    .mode    (acc_mode),
    .a_lo    (acc_a[1:0]),
    .wd      (acc_wd),
    .be      (be),
    .wr_word (wr_word),
    .ld_val  (ld_val),
    .flag    (lane_flag)
  );

`ifdef DMEM_WS_MISALIGN_FAULT_EN
  assign fault = lane_flag;
`else
  logic unused_flag;
  assign unused_flag = lane_flag;
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      mode_q  <= 3'd0;
      a_q     <= '0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= we;
        mode_q <= mode;
        a_q    <= a[AW+1:0];
        wd_q   <= wd;
      end
      if (go) begin
        rd_q  <= (acc_we || fault) ? 32'd0 : ld_val;
        err_q <= fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (go && acc_we && !fault && (|be)) begin
      mem[acc_idx] <= wr_word;
    end
  end

  assign rd    = rd_q;
  assign err   = err_q;
  assign ready = (state_q == RESP);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_ws.sv
// Self-checking bench for dmem_ws: byte-array reference model, per-cycle handshake
// compare, directed literal cases and randomized traffic; second instance at LATENCY=0.
module tb_dmem_ws;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
`ifdef DMEM_WS_MISALIGN_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [31:0] a = 32'd0, wd = 32'd0;
  logic [31:0] rd;
  logic        ready, busy, err;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [2:0]  mode0 = 3'd0;
  logic [31:0] a0 = 32'd0, wd0 = 32'd0;
  logic [31:0] rd0;
  logic        ready0, busy0, err0;

  int checks = 0;
  int errors = 0;

  logic [2:0] legal_modes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] bad_modes [3]   = '{3'b011, 3'b110, 3'b111};

  always #5 clk = ~clk;

  dmem_ws #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .mode(mode), .a(a), .wd(wd),
    .rd(rd), .ready(ready), .busy(busy), .err(err)
  );

  dmem_ws #(.DEPTH(4), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .mode(mode0), .a(a0), .wd(wd0),
    .rd(rd0), .ready(ready0), .busy(busy0), .err(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, accesses by size and offset.
  logic [7:0]  mbytes [DEPTH*4];
  int          cyc = 0;
  int          acc_cyc = -100;
  bit          pend = 1'b0;
  logic [31:0] exp_rd;
  logic        exp_err;

  function automatic void model_access(input logic w, input logic [2:0] m,
                                       input logic [31:0] addr, input logic [31:0] data,
                                       output logic [31:0] r, output logic e);
    int size, base, off;
    bit sgn, illegal, mis;
    longint v;
    size = 4; sgn = 0; illegal = 0;
    case (m)
      3'b000: begin size = 1; sgn = 1; end
      3'b001: begin size = 2; sgn = 1; end
      3'b010: size = 4;
      3'b100: size = 1;
      3'b101: size = 2;
      default: illegal = 1;
    endcase
    base = int'((addr >> 2) % DEPTH) * 4;
    off  = (int'(addr % 4) / size) * size;
    mis  = (int'(addr % 4) % size) != 0;
    e    = FAULT_EN && (illegal || mis);
    r    = 32'd0;
    if (illegal || e) return;
    if (w) begin
      for (int i = 0; i < size; i++) mbytes[base+off+i] = data[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(mbytes[base+off+i]) << (8*i));
      if (sgn && ((v >> (8*size-1)) & 1) == 1) v = v - (longint'(1) << (8*size));
      r = v[31:0];
    end
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      pend = 1'b0;
      foreach (mbytes[i]) mbytes[i] = 8'd0;
    end else if (req && !(pend && cyc <= acc_cyc + LATENCY)) begin
      model_access(we, mode, a, wd, exp_rd, exp_err);
      pend    = 1'b1;
      acc_cyc = cyc + 1;
    end
    cyc++;
  end

  // busy spans the LATENCY+1 cycles after acceptance; ready is the last of them.
  initial forever begin
    bit eb, er;
    @(negedge clk);
    if (cyc > 0) begin
      er = pend && (cyc == acc_cyc + LATENCY);
      eb = pend && (cyc >= acc_cyc) && (cyc <= acc_cyc + LATENCY);
      chk("cyc_busy", {31'd0, busy}, {31'd0, eb});
      chk("cyc_ready", {31'd0, ready}, {31'd0, er});
      if (er) begin
        chk("cyc_rd", rd, exp_rd);
        chk("cyc_err", {31'd0, err}, {31'd0, exp_err});
      end
    end
  end

  task automatic access(input logic w, input logic [2:0] m, input logic [31:0] addr,
                        input logic [31:0] data, input bit toggle,
                        output logic [31:0] r, output logic e, output int lat);
    int n;
    bit seen;
    @(negedge clk);
    req = 1'b1; we = w; mode = m; a = addr; wd = data;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ready) seen = 1;
      else if (toggle) begin
        req = 1'($urandom_range(0, 1));
        we  = ~we;
        a   = $urandom;
        wd  = $urandom;
      end
    end
    req = 1'b0;
    r = rd; e = err; lat = n;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL access_timeout: got no ready after %0d cycles expected ready", n);
    end
  endtask

  task automatic access0(input logic w, input logic [2:0] m, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] r, output int lat,
                         output logic b);
    int n;
    bit seen;
    @(negedge clk);
    req0 = 1'b1; we0 = w; mode0 = m; a0 = addr; wd0 = data;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (ready0) seen = 1;
    end
    req0 = 1'b0;
    r = rd0; lat = n; b = busy0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL access0_timeout: got no ready after %0d cycles expected ready", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e, b;
    int          lat, pulses;
    logic [2:0]  m;
    logic [31:0] ad;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_rd", rd, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    access(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, r, e, lat);
    chk("sw_latency", lat, 32'd3);
    access(0, 3'b010, 32'h10, 32'h0, 0, r, e, lat);
    chk("lw_deadbeef", r, 32'hDEADBEEF);
    chk("lw_err", {31'd0, e}, 32'd0);

    access(1, 3'b010, 32'h10, 32'h0, 0, r, e, lat);
    access(1, 3'b000, 32'h11, 32'h000000A5, 0, r, e, lat);
    chk("sb_rd_zero", r, 32'd0);
    access(0, 3'b010, 32'h10, 32'h0, 0, r, e, lat);
    chk("lw_after_sb", r, 32'h0000A500);
    access(0, 3'b000, 32'h11, 32'h0, 0, r, e, lat);
    chk("lb_signed", r, 32'hFFFFFFA5);
    access(0, 3'b100, 32'h11, 32'h0, 0, r, e, lat);
    chk("lbu", r, 32'h000000A5);

    access(1, 3'b001, 32'h22, 32'h00008001, 0, r, e, lat);
    access(0, 3'b001, 32'h22, 32'h0, 0, r, e, lat);
    chk("lh_signed", r, 32'hFFFF8001);
    access(0, 3'b101, 32'h22, 32'h0, 0, r, e, lat);
    chk("lhu", r, 32'h00008001);
    access(0, 3'b010, 32'h20, 32'h0, 0, r, e, lat);
    chk("lw_after_sh", r, 32'h80010000);

    access(1, 3'b010, 32'h100, 32'h12345678, 0, r, e, lat);
    access(0, 3'b010, 32'h000, 32'h0, 1, r, e, lat);
    chk("wrap_lw", r, 32'h12345678);
    chk("toggle_latency", lat, 32'd3);

    @(negedge clk);
    req = 1'b1; we = 1'b1; mode = 3'b010; a = 32'h40; wd = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("rst_mid_no_ready", pulses, 32'd0);
    access(0, 3'b010, 32'h40, 32'h0, 0, r, e, lat);
    chk("rst_mid_lw", r, 32'd0);

    access(1, 3'b010, 32'h41, 32'hCAFEF00D, 0, r, e, lat);
    chk("sw_mis_err", {31'd0, e}, {31'd0, FAULT_EN});
    access(0, 3'b010, 32'h40, 32'h0, 0, r, e, lat);
    chk("sw_mis_effect", r, FAULT_EN ? 32'd0 : 32'hCAFEF00D);
    access(0, 3'b010, 32'h41, 32'h0, 0, r, e, lat);
    chk("lw_mis_rd", r, FAULT_EN ? 32'd0 : 32'hCAFEF00D);
    chk("lw_mis_err", {31'd0, e}, {31'd0, FAULT_EN});

    access(1, 3'b010, 32'h10, 32'h11223344, 0, r, e, lat);
    access(0, 3'b011, 32'h10, 32'h0, 0, r, e, lat);
    chk("illegal_load_rd", r, 32'd0);
    chk("illegal_err", {31'd0, e}, {31'd0, FAULT_EN});
    access(1, 3'b111, 32'h10, 32'hFFFFFFFF, 0, r, e, lat);
    access(0, 3'b010, 32'h10, 32'h0, 0, r, e, lat);
    chk("illegal_no_write", r, 32'h11223344);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0) m = bad_modes[$urandom_range(0, 2)];
      else m = legal_modes[$urandom_range(0, 4)];
      ad = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ad = ad | ($urandom & 32'hFFFFF000);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(1'($urandom_range(0, 1)), m, ad, $urandom, $urandom_range(0, 9) == 0,
             r, e, lat);
    end

    access0(1, 3'b010, 32'h14, 32'hA5A50F0F, r, lat, b);
    chk("lat0_sw_latency", lat, 32'd1);
    chk("lat0_busy", {31'd0, b}, 32'd1);
    access0(0, 3'b010, 32'h04, 32'h0, r, lat, b);
    chk("lat0_lw_wrap", r, 32'hA5A50F0F);
    chk("lat0_lw_latency", lat, 32'd1);
    access0(0, 3'b000, 32'h07, 32'h0, r, lat, b);
    chk("lat0_lb", r, 32'hFFFFFFA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
